// File: rtl/act_dealloc_engine_pkg.sv
// Shared ACT types for the dealloc walker: entry layout, table geometry and FSM states.
// ACT_DEALLOC_SCRUB_EN selects whether a freed entry is zeroed or only invalidated.
package act_dealloc_engine_pkg;

  localparam int BLOCK_COUNT      = 16;
  localparam int BLOCK_COUNT_BITS = $clog2(BLOCK_COUNT);
  localparam int RID_BITS         = 8;
  localparam int OWNER_BITS       = 4;
  localparam int MASK_BITS        = 16;

  typedef struct packed {
    logic                  valid;
    logic [MASK_BITS-1:0]  read_mask;
    logic [MASK_BITS-1:0]  write_mask;
    logic [OWNER_BITS-1:0] owner;
    logic [RID_BITS-1:0]   reservation_id;
  } entry_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_BSY,
    ST_RD,
    ST_CHK,
    ST_FIN
  } dealloc_state_t;

  // Without scrubbing, masks/owner/rid survive so a debugger can see what was released.
  function automatic entry_t freed_entry(input entry_t e);
    entry_t f;
`ifdef ACT_DEALLOC_SCRUB_EN
    f = '0;
`else
    f       = e;
    f.valid = 1'b0;
`endif
    return f;
  endfunction

endpackage

// File: rtl/act_dealloc_engine.sv
// Walks every ACT entry on the act_mem dealloc port, freeing entries that match the
// requested rid and owner. Freed-entry format depends on ACT_DEALLOC_SCRUB_EN.
module act_dealloc_engine
  import act_dealloc_engine_pkg::*;
#(
  parameter int BLOCK_COUNT      = act_dealloc_engine_pkg::BLOCK_COUNT,
  parameter int BLOCK_COUNT_BITS = act_dealloc_engine_pkg::BLOCK_COUNT_BITS
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [RID_BITS-1:0]         req_rid,
  input  logic [OWNER_BITS-1:0]       req_owner,
  output logic                        done,
  output logic [BLOCK_COUNT_BITS:0]   freed_count,
  output logic                        perm_err,
  output logic                        act_cs,
  output logic                        act_malloc_dealloc,
  output logic                        act_dealloc_we,
  output logic [BLOCK_COUNT_BITS-1:0] act_dealloc_addr,
  output entry_t                      act_dealloc_wdata,
  input  entry_t                      act_dealloc_rdata,
  input  logic                        act_bsy
);

  localparam logic [BLOCK_COUNT_BITS-1:0] LAST_ADDR = BLOCK_COUNT_BITS'(BLOCK_COUNT - 1);

  dealloc_state_t              state;
  logic [RID_BITS-1:0]         rid_q;
  logic [OWNER_BITS-1:0]       owner_q;
  logic [BLOCK_COUNT_BITS:0]   cnt_acc;
  logic                        err_acc;

  logic                        rid_match;
  logic                        hit;
  logic                        foreign;
  logic                        abort;
  logic [BLOCK_COUNT_BITS:0]   cnt_next;
  logic                        err_next;

  // Read data only arrives in CHK, so the write decision is made combinationally there.
  assign rid_match = act_dealloc_rdata.valid && (act_dealloc_rdata.reservation_id == rid_q);
  assign hit       = rid_match && (act_dealloc_rdata.owner == owner_q);
  assign foreign   = rid_match && (act_dealloc_rdata.owner != owner_q);
  assign abort     = act_bsy && ((state == ST_RD) || (state == ST_CHK));
  assign cnt_next  = cnt_acc + (BLOCK_COUNT_BITS + 1)'(hit);
  assign err_next  = err_acc | foreign;

  assign act_dealloc_we    = (state == ST_CHK) && hit && !act_bsy;
  assign act_dealloc_wdata = act_dealloc_we ? freed_entry(act_dealloc_rdata) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= ST_IDLE;
      req_ready          <= 1'b1;
      done               <= 1'b0;
      freed_count        <= '0;
      perm_err           <= 1'b0;
      act_cs             <= 1'b0;
      act_malloc_dealloc <= 1'b0;
      act_dealloc_addr   <= '0;
      rid_q              <= '0;
      owner_q            <= '0;
      cnt_acc            <= '0;
      err_acc            <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        // Table re-initialising under us: report what was freed so far as a failed request.
        state              <= ST_FIN;
        act_cs             <= 1'b0;
        act_malloc_dealloc <= 1'b0;
        done               <= 1'b1;
        freed_count        <= cnt_acc;
        perm_err           <= 1'b1;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (req_valid) begin
              rid_q            <= req_rid;
              owner_q          <= req_owner;
              cnt_acc          <= '0;
              err_acc          <= 1'b0;
              act_dealloc_addr <= '0;
              req_ready        <= 1'b0;
              if (act_bsy) begin
                state <= ST_WAIT_BSY;
              end else begin
                state              <= ST_RD;
                act_cs             <= 1'b1;
                act_malloc_dealloc <= 1'b1;
              end
            end
          end
          ST_WAIT_BSY: begin
            if (!act_bsy) begin
              state              <= ST_RD;
              act_cs             <= 1'b1;
              act_malloc_dealloc <= 1'b1;
            end
          end
          ST_RD: state <= ST_CHK;
          ST_CHK: begin
            cnt_acc <= cnt_next;
            err_acc <= err_next;
            if (act_dealloc_addr == LAST_ADDR) begin
              state              <= ST_FIN;
              act_cs             <= 1'b0;
              act_malloc_dealloc <= 1'b0;
              done               <= 1'b1;
              freed_count        <= cnt_next;
              perm_err           <= err_next;
            end else begin
              act_dealloc_addr <= act_dealloc_addr + 1'b1;
              state            <= ST_RD;
            end
          end
          ST_FIN: begin
            state     <= ST_IDLE;
            req_ready <= 1'b1;
          end
          default: begin
            state              <= ST_IDLE;
            req_ready          <= 1'b1;
            act_cs             <= 1'b0;
            act_malloc_dealloc <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_act_dealloc_engine.sv
// Bench for act_dealloc_engine: behavioural ACT memory behind the engine plus a
// table-level model of what each request should free and report.
module tb_act_dealloc_engine;
  import act_dealloc_engine_pkg::*;

  localparam int N    = BLOCK_COUNT;
  localparam int CB   = BLOCK_COUNT_BITS;
  localparam int RSTW = 1 + 1 + (CB + 1) + 1 + 1 + 1 + 1 + CB + $bits(entry_t);

  logic                  clk;
  logic                  rst_n;
  logic                  req_valid;
  logic                  req_ready;
  logic [RID_BITS-1:0]   req_rid;
  logic [OWNER_BITS-1:0] req_owner;
  logic                  done;
  logic [CB:0]           freed_count;
  logic                  perm_err;
  logic                  act_cs;
  logic                  act_malloc_dealloc;
  logic                  act_dealloc_we;
  logic [CB-1:0]         act_dealloc_addr;
  entry_t                act_dealloc_wdata;
  entry_t                act_dealloc_rdata;
  logic                  act_bsy;

  act_dealloc_engine #(.BLOCK_COUNT(N), .BLOCK_COUNT_BITS(CB)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_rid            (req_rid),
    .req_owner          (req_owner),
    .done               (done),
    .freed_count        (freed_count),
    .perm_err           (perm_err),
    .act_cs             (act_cs),
    .act_malloc_dealloc (act_malloc_dealloc),
    .act_dealloc_we     (act_dealloc_we),
    .act_dealloc_addr   (act_dealloc_addr),
    .act_dealloc_wdata  (act_dealloc_wdata),
    .act_dealloc_rdata  (act_dealloc_rdata),
    .act_bsy            (act_bsy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural act_mem dealloc port: read-first, read data one cycle after the address.
  entry_t        mem [N];
  logic [N-1:0]  wtrace;
  logic          wtrace_clr;
  logic          pre_we;
  logic [CB-1:0] pre_addr;
  entry_t        pre_data;

  always @(posedge clk) begin
    if (pre_we) begin
      mem[pre_addr] <= pre_data;
    end else if (act_cs) begin
      if (act_dealloc_we) mem[act_dealloc_addr] <= act_dealloc_wdata;
      act_dealloc_rdata <= mem[act_dealloc_addr];
    end
    if (wtrace_clr) wtrace <= '0;
    else if (act_cs && act_dealloc_we) wtrace[act_dealloc_addr] <= 1'b1;
  end

  // Reference model state: tab is the table before a request, exp_* what it should become.
  entry_t       tab     [N];
  entry_t       exp_tab [N];
  int           exp_cnt;
  bit           exp_err;
  logic [N-1:0] exp_wmask;
  int           n_checks = 0;
  int           n_pass   = 0;

  function automatic entry_t mk_entry(input bit v, input int owner, input int rid,
                                      input logic [MASK_BITS-1:0] rm, input logic [MASK_BITS-1:0] wm);
    entry_t e;
    e.valid          = v;
    e.read_mask      = rm;
    e.write_mask     = wm;
    e.owner          = OWNER_BITS'(owner);
    e.reservation_id = RID_BITS'(rid);
    return e;
  endfunction

  task automatic clear_tab();
    for (int i = 0; i < N; i++) tab[i] = '0;
  endtask

  task automatic load_table();
    for (int i = 0; i < N; i++) begin
      pre_we   = 1'b1;
      pre_addr = CB'(i);
      pre_data = tab[i];
      @(posedge clk); #1;
    end
    pre_we = 1'b0;
  endtask

  // Entries below 'limit' are visited; a limit short of N means the scan was cut off.
  task automatic model_scan(input int rid, input int owner, input int limit);
    exp_cnt   = 0;
    exp_err   = (limit < N);
    exp_wmask = '0;
    for (int i = 0; i < N; i++) begin
      exp_tab[i] = tab[i];
      if (i < limit && tab[i].valid && tab[i].reservation_id == RID_BITS'(rid)) begin
        if (tab[i].owner == OWNER_BITS'(owner)) begin
`ifdef ACT_DEALLOC_SCRUB_EN
          exp_tab[i] = '0;
`else
          exp_tab[i].valid = 1'b0;
`endif
          exp_cnt++;
          exp_wmask[i] = 1'b1;
        end else begin
          exp_err = 1'b1;
        end
      end
    end
  endtask

  task automatic run_request(input int rid, input int owner, input int bsy_at, output int lat);
    for (int w = 0; w < 10 && !req_ready; w++) begin
      @(posedge clk); #1;
    end
    req_rid    = RID_BITS'(rid);
    req_owner  = OWNER_BITS'(owner);
    req_valid  = 1'b1;
    wtrace_clr = 1'b1;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    wtrace_clr = 1'b0;
    lat = 1;
    while (lat < 200) begin
      if (lat == bsy_at) act_bsy = 1'b1;
      if (done) break;
      @(posedge clk); #1;
      lat++;
    end
    act_bsy = 1'b0;
  endtask

  task automatic test_reset();
    logic [RSTW-1:0] obs, expv;
    rst_n = 1'b0; act_bsy = 1'b1; req_valid = 1'b0; req_rid = '0; req_owner = '0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0; wtrace_clr = 1'b1;
    expv = {1'b1, {(RSTW-1){1'b0}}};
    repeat (3) @(posedge clk);
    #1;
    obs = {req_ready, done, freed_count, perm_err, act_cs, act_malloc_dealloc,
           act_dealloc_we, act_dealloc_addr, act_dealloc_wdata};
    n_checks++;
    if (obs !== expv) $display("[TB] FAIL reset_hold: got %h want %h", obs, expv);
    else n_pass++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    wtrace_clr = 1'b0;
    obs = {req_ready, done, freed_count, perm_err, act_cs, act_malloc_dealloc,
           act_dealloc_we, act_dealloc_addr, act_dealloc_wdata};
    n_checks++;
    if (obs !== expv) $display("[TB] FAIL reset_release: got %h want %h", obs, expv);
    else n_pass++;
  endtask

  task automatic test_wait_bsy();
    int  lat;
    bit  bus_busy;
    clear_tab();
    tab[2] = mk_entry(1, 1, 4, 16'h00FF, 16'h0F0F);
    load_table();
    model_scan(4, 1, N);
    req_rid = RID_BITS'(4); req_owner = OWNER_BITS'(1); req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    bus_busy  = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (act_cs !== 1'b0 || req_ready !== 1'b0) bus_busy = 1'b1;
      if (c < 4) begin
        @(posedge clk); #1;
      end
    end
    n_checks++;
    if (bus_busy) $display("[TB] FAIL wait_bsy_quiet: act_cs/req_ready active while bsy (cs=%b ready=%b) want 0/0", act_cs, req_ready);
    else n_pass++;
    act_bsy = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({act_cs, act_malloc_dealloc, act_dealloc_we, act_dealloc_addr} !== {3'b110, {CB{1'b0}}})
      $display("[TB] FAIL wait_bsy_rd0: got cs=%b md=%b we=%b addr=%0d want 1/1/0/0", act_cs, act_malloc_dealloc, act_dealloc_we, act_dealloc_addr);
    else n_pass++;
    lat = 5;
    while (lat < 200 && !done) begin
      @(posedge clk); #1;
      lat++;
    end
    n_checks++;
    if (lat !== 2*N + 1 + 4) $display("[TB] FAIL wait_bsy_latency: got %0d want %0d", lat, 2*N + 5);
    else n_pass++;
    n_checks++;
    if (freed_count !== (CB+1)'(exp_cnt) || perm_err !== exp_err)
      $display("[TB] FAIL wait_bsy_result: got count=%0d err=%b want count=%0d err=%b", freed_count, perm_err, exp_cnt, exp_err);
    else n_pass++;
    for (int i = 0; i < N; i++) tab[i] = exp_tab[i];
  endtask

  task automatic test_free_owner();
    int lat;
    int bad;
    clear_tab();
    tab[5]  = mk_entry(1, 3, 5, 16'h000F, 16'hF000);
    tab[10] = mk_entry(1, 7, 10, 16'h1234, 16'h5678);
    load_table();
    model_scan(5, 3, N);
    run_request(5, 3, -1, lat);
    n_checks++;
    if (lat !== 2*N + 1) $display("[TB] FAIL free_latency: got %0d want %0d", lat, 2*N + 1);
    else n_pass++;
    n_checks++;
    if (freed_count !== (CB+1)'(exp_cnt) || perm_err !== exp_err)
      $display("[TB] FAIL free_result: got count=%0d err=%b want count=%0d err=%b", freed_count, perm_err, exp_cnt, exp_err);
    else n_pass++;
    @(posedge clk); #1;
    bad = -1;
    for (int i = 0; i < N; i++) if (mem[i] !== exp_tab[i] && bad < 0) bad = i;
    n_checks++;
    if (bad >= 0) $display("[TB] FAIL free_table: entry %0d got %h want %h", bad, mem[bad], exp_tab[bad]);
    else n_pass++;
    n_checks++;
`ifdef ACT_DEALLOC_SCRUB_EN
    if (mem[5] !== entry_t'('0)) $display("[TB] FAIL free_addr5_fmt: got %h want all zero", mem[5]);
    else n_pass++;
`else
    if (mem[5].valid !== 1'b0 || mem[5].read_mask !== 16'h000F || mem[5].write_mask !== 16'hF000)
      $display("[TB] FAIL free_addr5_fmt: got v=%b rm=%h wm=%h want v=0 rm=000f wm=f000", mem[5].valid, mem[5].read_mask, mem[5].write_mask);
    else n_pass++;
`endif
    n_checks++;
    if (mem[10].valid !== 1'b1 || mem[10].owner !== OWNER_BITS'(7))
      $display("[TB] FAIL free_addr10_kept: got v=%b owner=%0d want v=1 owner=7", mem[10].valid, mem[10].owner);
    else n_pass++;
    for (int i = 0; i < N; i++) tab[i] = exp_tab[i];
  endtask

  task automatic test_perm_err();
    int lat;
    model_scan(10, 3, N);
    run_request(10, 3, -1, lat);
    n_checks++;
    if (lat !== 2*N + 1 || freed_count !== (CB+1)'(exp_cnt) || perm_err !== exp_err)
      $display("[TB] FAIL perm_result: got lat=%0d count=%0d err=%b want lat=%0d count=%0d err=%b", lat, freed_count, perm_err, 2*N + 1, exp_cnt, exp_err);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (mem[10].valid !== 1'b1 || mem[10].owner !== OWNER_BITS'(7) || wtrace !== '0)
      $display("[TB] FAIL perm_no_write: got v=%b owner=%0d wtrace=%h want v=1 owner=7 wtrace=0", mem[10].valid, mem[10].owner, wtrace);
    else n_pass++;
  endtask

  task automatic test_last_addr();
    int           lat;
    int           bad;
    logic [N-1:0] want_trace;
    clear_tab();
    tab[0]  = mk_entry(1, 2, 9, 16'h0001, 16'h0002);
    tab[3]  = mk_entry(0, 2, 9, 16'h0003, 16'h0004);
    tab[7]  = mk_entry(1, 2, 9, 16'h0005, 16'h0006);
    tab[15] = mk_entry(1, 2, 9, 16'h0007, 16'h0008);
    load_table();
    model_scan(9, 2, N);
    want_trace = 16'b1000_0000_1000_0001;
    run_request(9, 2, -1, lat);
    n_checks++;
    if (lat !== 2*N + 1 || freed_count !== (CB+1)'(3) || perm_err !== 1'b0)
      $display("[TB] FAIL last_result: got lat=%0d count=%0d err=%b want lat=%0d count=3 err=0", lat, freed_count, perm_err, 2*N + 1);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (wtrace !== want_trace) $display("[TB] FAIL last_wtrace: got %b want %b", wtrace, want_trace);
    else n_pass++;
    bad = -1;
    for (int i = 0; i < N; i++) if (mem[i] !== exp_tab[i] && bad < 0) bad = i;
    n_checks++;
    if (bad >= 0) $display("[TB] FAIL last_table: entry %0d got %h want %h", bad, mem[bad], exp_tab[bad]);
    else n_pass++;
    for (int i = 0; i < N; i++) tab[i] = exp_tab[i];
  endtask

  task automatic test_bsy_abort();
    int lat;
    int bad;
    clear_tab();
    tab[0] = mk_entry(1, 1, 6, 16'h1111, 16'h2222);
    tab[2] = mk_entry(1, 1, 6, 16'h3333, 16'h4444);
    tab[6] = mk_entry(1, 1, 6, 16'h5555, 16'h6666);
    tab[9] = mk_entry(1, 1, 6, 16'h7777, 16'h8888);
    load_table();
    // bsy rises during the CHK cycle of address 6 (cycle 14), so address 6 must not be written.
    model_scan(6, 1, 6);
    run_request(6, 1, 14, lat);
    n_checks++;
    if (lat !== 15 || freed_count !== (CB+1)'(exp_cnt) || perm_err !== 1'b1)
      $display("[TB] FAIL abort_result: got lat=%0d count=%0d err=%b want lat=15 count=%0d err=1", lat, freed_count, perm_err, exp_cnt);
    else n_pass++;
    @(posedge clk); #1;
    bad = -1;
    for (int i = 0; i < N; i++) if (mem[i] !== exp_tab[i] && bad < 0) bad = i;
    n_checks++;
    if (bad >= 0 || wtrace !== exp_wmask)
      $display("[TB] FAIL abort_table: first bad entry %0d wtrace=%b want wtrace=%b", bad, wtrace, exp_wmask);
    else n_pass++;
    for (int i = 0; i < N; i++) tab[i] = exp_tab[i];
  endtask

  task automatic test_reset_mid_scan();
    logic [RSTW-1:0] obs, expv;
    int lat;
    int bad;
    clear_tab();
    tab[0]  = mk_entry(1, 2, 9, 16'hAAAA, 16'hBBBB);
    tab[7]  = mk_entry(1, 2, 9, 16'hCCCC, 16'hDDDD);
    tab[15] = mk_entry(1, 2, 9, 16'hEEEE, 16'hFFFF);
    load_table();
    expv = {1'b1, {(RSTW-1){1'b0}}};
    req_rid = RID_BITS'(9); req_owner = OWNER_BITS'(2); req_valid = 1'b1; wtrace_clr = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; wtrace_clr = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    obs = {req_ready, done, freed_count, perm_err, act_cs, act_malloc_dealloc,
           act_dealloc_we, act_dealloc_addr, act_dealloc_wdata};
    n_checks++;
    if (obs !== expv) $display("[TB] FAIL midreset_outputs: got %h want %h", obs, expv);
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    // Cycle 12 is the CHK of address 5, so only addresses 0..4 were processed.
    model_scan(9, 2, 5);
    bad = -1;
    for (int i = 0; i < N; i++) if (mem[i] !== exp_tab[i] && bad < 0) bad = i;
    n_checks++;
    if (bad >= 0) $display("[TB] FAIL midreset_table: entry %0d got %h want %h", bad, mem[bad], exp_tab[bad]);
    else n_pass++;
    for (int i = 0; i < N; i++) tab[i] = exp_tab[i];
    model_scan(9, 2, N);
    run_request(9, 2, -1, lat);
    n_checks++;
    if (lat !== 2*N + 1 || freed_count !== (CB+1)'(exp_cnt) || perm_err !== exp_err)
      $display("[TB] FAIL midreset_rerun: got lat=%0d count=%0d err=%b want lat=%0d count=%0d err=%b", lat, freed_count, perm_err, 2*N + 1, exp_cnt, exp_err);
    else n_pass++;
    for (int i = 0; i < N; i++) tab[i] = exp_tab[i];
  endtask

  task automatic test_back_to_back();
    int lat;
    model_scan(9, 2, N);
    run_request(9, 2, -1, lat);
    n_checks++;
    if (done !== 1'b1 || req_ready !== 1'b0)
      $display("[TB] FAIL b2b_fin: got done=%b ready=%b want 1/0", done, req_ready);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0 || req_ready !== 1'b1)
      $display("[TB] FAIL b2b_ready: got done=%b ready=%b want 0/1", done, req_ready);
    else n_pass++;
    run_request(9, 2, -1, lat);
    n_checks++;
    if (lat !== 2*N + 1 || freed_count !== (CB+1)'(exp_cnt))
      $display("[TB] FAIL b2b_second: got lat=%0d count=%0d want lat=%0d count=%0d", lat, freed_count, 2*N + 1, exp_cnt);
    else n_pass++;
  endtask

  task automatic test_random();
    int lat;
    int bad;
    int rid;
    int owner;
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < N; i++)
        tab[i] = mk_entry($urandom_range(1, 0) == 1, $urandom_range(3, 0), $urandom_range(3, 0),
                          MASK_BITS'($urandom), MASK_BITS'($urandom));
      load_table();
      rid   = $urandom_range(3, 0);
      owner = $urandom_range(3, 0);
      model_scan(rid, owner, N);
      run_request(rid, owner, -1, lat);
      n_checks++;
      if (lat !== 2*N + 1 || freed_count !== (CB+1)'(exp_cnt) || perm_err !== exp_err)
        $display("[TB] FAIL rand%0d_result: got lat=%0d count=%0d err=%b want lat=%0d count=%0d err=%b", it, lat, freed_count, perm_err, 2*N + 1, exp_cnt, exp_err);
      else n_pass++;
      @(posedge clk); #1;
      bad = -1;
      for (int i = 0; i < N; i++) if (mem[i] !== exp_tab[i] && bad < 0) bad = i;
      n_checks++;
      if (bad >= 0 || wtrace !== exp_wmask)
        $display("[TB] FAIL rand%0d_table: first bad entry %0d wtrace=%b want wtrace=%b", it, bad, wtrace, exp_wmask);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_wait_bsy();
    test_free_owner();
    test_perm_err();
    test_last_addr();
    test_bsy_abort();
    test_reset_mid_scan();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/act_dealloc_engine.md
# act_dealloc_engine

Request-driven deallocation walker that sits directly upstream of `act_mem` on its dealloc port. It accepts a (reservation_id, owner) pair and scans every ACT entry through the dealloc read/write port. Matching valid entries owned by the requester are freed; matching entries held by a different owner are left intact and flagged. It reports completion with a freed-block count and a permission-error flag.

## Interface
Parameters:
- `BLOCK_COUNT`, package default: number of ACT entries scanned.
- `BLOCK_COUNT_BITS`, package default: address width, equal to $clog2(BLOCK_COUNT).

Ports (`entry_t` comes from `mpu_common.svh`):
- `clk` in 1: single clock; all state changes on posedge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `req_valid` in 1: dealloc request present.
- `req_ready` out 1: engine can accept a request; high only in IDLE.
- `req_rid` in RID_BITS: reservation_id to free.
- `req_owner` in OWNER_BITS: requesting owner.
- `done` out 1: one-cycle completion pulse.
- `freed_count` out BLOCK_COUNT_BITS+1: number of entries freed by the last request; held until the next acceptance.
- `perm_err` out 1: last request hit at least one rid match with a foreign owner; held like `freed_count`.
- `act_cs` out 1: drives `act_mem.cs`.
- `act_malloc_dealloc` out 1: drives `act_mem.malloc_dealloc`; 1 whenever `act_cs` is 1.
- `act_dealloc_we` out 1: drives `act_mem.dealloc_we`.
- `act_dealloc_addr` out BLOCK_COUNT_BITS: drives `act_mem.dealloc_addr`.
- `act_dealloc_wdata` out entry_t: drives `act_mem.dealloc_wdata`.
- `act_dealloc_rdata` in entry_t: from `act_mem.dealloc_rdata`; valid the cycle after a read address is presented.
- `act_bsy` in 1: from `act_mem.bsy`; high while the table initialises.

## Operation
- States: IDLE, WAIT_BSY, RD, CHK, FIN.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`: latch rid and owner, clear the count and error accumulators, and reset the scan address to 0.
  - Go to WAIT_BSY if `act_bsy`, else RD.
- WAIT_BSY: no `act_cs`; go to RD when `act_bsy`=0.
- RD: `act_cs`=1, `act_dealloc_we`=0, `act_dealloc_addr`=scan address; go to CHK.
- CHK: evaluate `act_dealloc_rdata`, with `act_cs`=1 and the same address held.
  - Entry valid, rid match, owner match: `act_dealloc_we`=1 with the freed entry on wdata; count += 1.
  - Entry valid, rid match, owner mismatch: no write; set the perm_err accumulator.
  - Otherwise: no write.
  - Next state: if address = BLOCK_COUNT-1, go to FIN; else address += 1 and go to RD.
- FIN: `done`=1; publish the accumulators to `freed_count`/`perm_err`; go to IDLE.
- Invalid entries are never written, whatever their rid.
- `act_bsy` rising in RD or CHK: abort to FIN.
  - Any write in flight that cycle is suppressed.
  - `perm_err` is forced to 1.
  - The count reports the entries freed so far.
- `req_valid` outside IDLE is ignored; there is no queueing.
- Reset mid-scan: immediate return to IDLE with all outputs at reset values; already-freed entries stay freed.

## Timing
- Reset values:
  - `req_ready`=1.
  - `done`=0, `freed_count`=0, `perm_err`=0.
  - `act_cs`=0, `act_malloc_dealloc`=0, `act_dealloc_we`=0, `act_dealloc_addr`=0, `act_dealloc_wdata`='0.
- Acceptance occurs on the edge where `req_valid`&&`req_ready`.
- With `act_bsy`=0, `done` is high in cycle 2*BLOCK_COUNT+1 after acceptance; every wait cycle in WAIT_BSY adds one.
- Back-to-back: `req_ready` returns the cycle after `done`.
- Write and read share the address: the CHK write lands at the edge ending CHK, and the next RD reads address+1.
- The count never exceeds BLOCK_COUNT, so no saturation is needed.

## Configuration
- `ACT_DEALLOC_SCRUB_EN` defined: a freed entry is written as all-zero, clearing valid, masks, owner and rid.
- Undefined: a freed entry is written as rdata with only `valid` cleared; masks, owner and rid are preserved for debug readback.

## Structure
- Package `mpu_common.svh` holds:
  - `entry_t` (valid, read_mask, write_mask, owner, reservation_id);
  - BLOCK_COUNT and BLOCK_COUNT_BITS;
  - RID_BITS and OWNER_BITS;
  - a new `dealloc_state_t` enum.
- No sub-module: a single FSM plus the accumulators.

## Test plan
All scenarios use BLOCK_COUNT=16 with `act_mem` instanced behind the engine.
1. Reset with `act_bsy` high, then `req_valid` -> engine sits in WAIT_BSY with `act_cs`=0 and starts RD addr 0 the cycle after `bsy` falls.
2. Preload addr5 {valid=1, owner=3, rid=5} and addr10 {valid=1, owner=7, rid=10}; request rid=5 owner=3 -> `done` at cycle 33, `freed_count`=1, `perm_err`=0; addr5 valid=0; addr10 unchanged.
3. Request rid=10 owner=3 -> `freed_count`=0, `perm_err`=1; addr10 still valid with owner=7.
4. rid=9 owner=2 at addrs 0, 7 and 15, plus an invalid rid=9 at addr 3; request rid=9 owner=2 -> `freed_count`=3; addr3 is never written (checked via `act_dealloc_we` trace); last-address handling is exercised.
5. Pulse `rst_n` low at cycle 12 of a scan -> outputs return to reset values; entries freed before cycle 12 stay freed; a following request completes normally.
6. With `ACT_DEALLOC_SCRUB_EN`, the freed addr5 reads all zeros; without it, addr5 reads read_mask=0000_0000_0000_1111, write_mask=1111_0000_0000_0000, valid=0.
